// File: rtl/single_ttc_decoder.sv
// Receive side of the 2-bit legacy TTC link. It deserialises 3-symbol frames into one-cycle command pulses.
// It also keeps the local BCID and event-ID counters that tag each trigger.
module single_ttc_decoder #(
    parameter int BC_MAX     = 3563,
    parameter int EVID_WIDTH = 12,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk_40,
    input  logic                  rst_40_n,
    input  logic [1:0]            encode_ttc,
    output logic                  trigger,
    output logic                  bc_reset,
    output logic                  event_reset,
    output logic                  master_reset,
    output logic                  frame_err,
    output logic [11:0]           bcid,
    output logic [11:0]           trig_bcid,
    output logic [EVID_WIDTH-1:0] trig_evid,
    output logic [ERR_WIDTH-1:0]  err_count
);

    localparam logic [11:0] BC_LAST = 12'(BC_MAX);

    typedef enum logic [1:0] {IDLE, SYM1, SYM2} state_t;

    state_t                  state_reg;
    logic [1:0]              ttc_reg;
    logic [1:0]              s1_reg;
    logic                    trig_pend_reg;
    logic                    bcr_pend_reg;
    logic                    ecr_pend_reg;
    logic                    mr_pend_reg;
    logic                    err_pend_reg;
    logic [EVID_WIDTH-1:0]   evid_reg;
    logic [11:0]             bcid_next;
    logic                    sym_bad;
    logic                    s1_bad;

    // 01 and 10 are the only illegal symbols; 00 and 11 always have a meaning.
    assign sym_bad = ttc_reg[1] ^ ttc_reg[0];
    assign s1_bad  = s1_reg[1] ^ s1_reg[0];

    always_comb begin
        bcid_next = (bcid == BC_LAST) ? 12'd0 : bcid + 12'd1;
        if (bcr_pend_reg)
            bcid_next = 12'd0;
    end

    // Decoded commands land in the *_pend_reg stage first, so every pulse is one cycle after the decode.
    always_ff @(posedge clk_40 or negedge rst_40_n) begin
        if (!rst_40_n) begin
            state_reg     <= IDLE;
            ttc_reg       <= 2'b00;
            s1_reg        <= 2'b00;
            trig_pend_reg <= 1'b0;
            bcr_pend_reg  <= 1'b0;
            ecr_pend_reg  <= 1'b0;
            mr_pend_reg   <= 1'b0;
            err_pend_reg  <= 1'b0;
            evid_reg      <= '0;
            trigger       <= 1'b0;
            bc_reset      <= 1'b0;
            event_reset   <= 1'b0;
            master_reset  <= 1'b0;
            frame_err     <= 1'b0;
            bcid          <= 12'd0;
            trig_bcid     <= 12'd0;
            trig_evid     <= '0;
            err_count     <= '0;
        end else begin
            ttc_reg       <= encode_ttc;
            trig_pend_reg <= 1'b0;
            bcr_pend_reg  <= 1'b0;
            ecr_pend_reg  <= 1'b0;
            mr_pend_reg   <= 1'b0;
            err_pend_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (ttc_reg == 2'b11)
                        state_reg <= SYM1;
                    else if (sym_bad)
                        err_pend_reg <= 1'b1;
                end
                SYM1: begin
                    s1_reg    <= ttc_reg;
                    state_reg <= SYM2;
                end
                SYM2: begin
                    state_reg <= IDLE;
                    if (s1_bad || sym_bad)
                        err_pend_reg <= 1'b1;
                    else begin
                        case ({s1_reg[1], ttc_reg[1]})
                            2'b00:   trig_pend_reg <= 1'b1;
                            2'b10:   bcr_pend_reg  <= 1'b1;
                            2'b11:   ecr_pend_reg  <= 1'b1;
                            default: mr_pend_reg   <= 1'b1;
                        endcase
                    end
                end
                default: state_reg <= IDLE;
            endcase

            trigger      <= trig_pend_reg;
            bc_reset     <= bcr_pend_reg;
            event_reset  <= ecr_pend_reg;
            master_reset <= mr_pend_reg;
            frame_err    <= err_pend_reg;
            bcid         <= bcid_next;

            // The trigger tag captures the bcid value that is visible alongside the trigger pulse.
            if (trig_pend_reg) begin
                trig_bcid <= bcid_next;
                trig_evid <= evid_reg;
                evid_reg  <= evid_reg + EVID_WIDTH'(1);
            end else if (ecr_pend_reg || mr_pend_reg) begin
                evid_reg  <= '0;
            end

            if (err_pend_reg && (err_count != '1))
                err_count <= err_count + ERR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_single_ttc_decoder.sv
// Self-checking bench for single_ttc_decoder: a frame-level symbol parser predicts every output on every cycle.
`timescale 1ns/1ps
module tb_single_ttc_decoder;

    localparam int BC_MAX = 3563;
    localparam int EVW    = 12;
    localparam int ERW    = 8;

    localparam int EV_NONE = 0, EV_TRIG = 1, EV_BCR = 2, EV_ECR = 3, EV_MR = 4, EV_ERR = 5;

    logic            clk_40 = 1'b0;
    logic            rst_40_n = 1'b0;
    logic [1:0]      encode_ttc = 2'b00;
    logic            trigger, bc_reset, event_reset, master_reset, frame_err;
    logic [11:0]     bcid, trig_bcid;
    logic [EVW-1:0]  trig_evid;
    logic [ERW-1:0]  err_count;

    single_ttc_decoder #(.BC_MAX(BC_MAX), .EVID_WIDTH(EVW), .ERR_WIDTH(ERW)) dut (
        .clk_40       (clk_40),
        .rst_40_n     (rst_40_n),
        .encode_ttc   (encode_ttc),
        .trigger      (trigger),
        .bc_reset     (bc_reset),
        .event_reset  (event_reset),
        .master_reset (master_reset),
        .frame_err    (frame_err),
        .bcid         (bcid),
        .trig_bcid    (trig_bcid),
        .trig_evid    (trig_evid),
        .err_count    (err_count)
    );

    always #12 clk_40 = ~clk_40;

    typedef struct {
        int k;
        int sig;
        int val;
    } pin_t;

    pin_t       pins[$];
    logic [1:0] syms[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cur_k = 0;
    string      cur_tag = "";

    function automatic int dut_val(int sig);
        case (sig)
            0:       return int'(trigger);
            1:       return int'(bc_reset);
            2:       return int'(event_reset);
            3:       return int'(master_reset);
            4:       return int'(frame_err);
            5:       return int'(bcid);
            6:       return int'(trig_bcid);
            7:       return int'(trig_evid);
            default: return int'(err_count);
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s/%s k=%0d actual=%0d required=%0d", cur_tag, name, cur_k, act, exp);
        end
    endtask

    task automatic check_zero();
        n_vec++;
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_bc_reset", int'(bc_reset), 0);
        chk("rst_event_reset", int'(event_reset), 0);
        chk("rst_master_reset", int'(master_reset), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_bcid", int'(bcid), 0);
        chk("rst_trig_bcid", int'(trig_bcid), 0);
        chk("rst_trig_evid", int'(trig_evid), 0);
        chk("rst_err_count", int'(err_count), 0);
    endtask

    function automatic logic is_bad(logic [1:0] s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    task automatic pin(int k, int sig, int val);
        pin_t p;
        p.k = k; p.sig = sig; p.val = val;
        pins.push_back(p);
    endtask

    task automatic push_frame(logic [1:0] a, logic [1:0] b, logic [1:0] c);
        syms.push_back(a); syms.push_back(b); syms.push_back(c);
    endtask

    task automatic push_idle(int n);
        for (int i = 0; i < n; i++) syms.push_back(2'b00);
    endtask

    // Reset the DUT, then stream syms[] and check all outputs after every edge.
    task automatic run_epoch(string tag);
        int n = syms.size();
        int ev[];
        int i;
        int m_bcid = 0, m_tbcid = 0, m_tevid = 0, m_evid = 0, m_err = 0;
        int n_pulses = 0;
        ev = new[n + 6];
        foreach (ev[j]) ev[j] = EV_NONE;
        cur_tag = tag;

        // Frame-level parse: s0 at index i gives its event at i+4; a stray illegal symbol in idle at i+2.
        i = 0;
        while (i < n) begin
            if (syms[i] == 2'b11) begin
                if (i + 2 >= n) break;
                if (is_bad(syms[i+1]) || is_bad(syms[i+2]))  ev[i+4] = EV_ERR;
                else if (syms[i+1] == 2'b00 && syms[i+2] == 2'b00) ev[i+4] = EV_TRIG;
                else if (syms[i+1] == 2'b11 && syms[i+2] == 2'b00) ev[i+4] = EV_BCR;
                else if (syms[i+1] == 2'b11 && syms[i+2] == 2'b11) ev[i+4] = EV_ECR;
                else ev[i+4] = EV_MR;
                i += 3;
            end else begin
                if (is_bad(syms[i])) ev[i+2] = EV_ERR;
                i++;
            end
        end

        cur_k = -1;
        rst_40_n = 1'b0;
        encode_ttc = 2'b00;
        #1;
        check_zero();
        repeat (2) begin
            @(negedge clk_40);
            check_zero();
        end
        rst_40_n = 1'b1;

        for (int k = 0; k < n; k++) begin
            encode_ttc = syms[k];
            @(posedge clk_40);
            @(negedge clk_40);
            cur_k = k;
            m_bcid = (ev[k] == EV_BCR) ? 0 : ((m_bcid == BC_MAX) ? 0 : m_bcid + 1);
            if (ev[k] == EV_TRIG) begin
                m_tbcid = m_bcid;
                m_tevid = m_evid;
                m_evid  = (m_evid + 1) % (1 << EVW);
            end else if (ev[k] == EV_ECR || ev[k] == EV_MR) begin
                m_evid = 0;
            end
            if (ev[k] == EV_ERR && m_err < (1 << ERW) - 1) m_err++;
            if (ev[k] != EV_NONE) n_pulses++;

            n_vec++;
            chk("trigger", int'(trigger), int'(ev[k] == EV_TRIG));
            chk("bc_reset", int'(bc_reset), int'(ev[k] == EV_BCR));
            chk("event_reset", int'(event_reset), int'(ev[k] == EV_ECR));
            chk("master_reset", int'(master_reset), int'(ev[k] == EV_MR));
            chk("frame_err", int'(frame_err), int'(ev[k] == EV_ERR));
            chk("bcid", int'(bcid), m_bcid);
            chk("trig_bcid", int'(trig_bcid), m_tbcid);
            chk("trig_evid", int'(trig_evid), m_tevid);
            chk("err_count", int'(err_count), m_err);
            foreach (pins[p]) begin
                if (pins[p].k == k) begin
                    n_vec++;
                    chk($sformatf("pin%0d", pins[p].sig), dut_val(pins[p].sig), pins[p].val);
                end
            end
        end
        $display("epoch %s: %0d symbols, %0d expected pulses", tag, n, n_pulses);
        syms.delete();
        pins.delete();
    endtask

    task automatic gen_random(int nitems);
        for (int t = 0; t < nitems; t++) begin
            int r = $urandom_range(99, 0);
            logic [1:0] bad = $urandom_range(1, 0) ? 2'b01 : 2'b10;
            logic [1:0] a = $urandom_range(1, 0) ? 2'b11 : 2'b00;
            logic [1:0] b = $urandom_range(1, 0) ? 2'b11 : 2'b00;
            if (r < 60)      push_frame(2'b11, a, b);
            else if (r < 75) push_idle($urandom_range(4, 1));
            else if (r < 82) push_frame(2'b11, bad, b);
            else if (r < 89) push_frame(2'b11, a, bad);
            else             syms.push_back(bad);
        end
        push_idle(6);
    endtask

    initial begin
        // Single trigger after 10 idles, then a second trigger to show evid advanced.
        push_idle(10); push_frame(2'b11, 2'b00, 2'b00);
        push_idle(7);  push_frame(2'b11, 2'b00, 2'b00);
        push_idle(8);
        pin(13, 0, 0); pin(14, 0, 1); pin(15, 0, 0);
        pin(14, 7, 0); pin(14, 6, 15); pin(24, 7, 1);
        run_epoch("trigger");

        // BCR landing where bcid would read 101, then a full orbit of free running.
        push_idle(96); push_frame(2'b11, 2'b11, 2'b00);
        push_idle(3671 - 99);
        pin(99, 5, 100); pin(100, 1, 1); pin(100, 5, 0); pin(101, 5, 1);
        pin(3663, 5, 3563); pin(3664, 5, 0);
        run_epoch("bcr_wrap");

        // Back-to-back trig, trig, ECR, trig.
        push_idle(5);
        push_frame(2'b11, 2'b00, 2'b00); push_frame(2'b11, 2'b00, 2'b00);
        push_frame(2'b11, 2'b11, 2'b11); push_frame(2'b11, 2'b00, 2'b00);
        push_idle(6);
        pin(9, 0, 1); pin(12, 0, 1); pin(15, 2, 1); pin(18, 0, 1);
        pin(9, 7, 0); pin(12, 7, 1); pin(18, 7, 0);
        run_epoch("b2b");

        // Master reset clears evid only; illegal s1 gives a frame error.
        push_idle(2);
        push_frame(2'b11, 2'b00, 2'b00); push_idle(1);
        push_frame(2'b11, 2'b00, 2'b11); push_idle(1);
        push_frame(2'b11, 2'b00, 2'b00); push_idle(1);
        push_frame(2'b11, 2'b10, 2'b00); push_idle(5);
        pin(10, 3, 1); pin(10, 0, 0); pin(14, 7, 0);
        pin(18, 4, 1); pin(18, 0, 0); pin(18, 9, 1);
        run_epoch("mr_err");

        // 300 stray 01 symbols saturate the error counter.
        push_idle(2);
        for (int j = 0; j < 300; j++) syms.push_back(2'b01);
        push_idle(6);
        pin(4, 4, 1); pin(4, 9, 1); pin(257, 9, 254); pin(258, 9, 255); pin(306, 9, 255);
        run_epoch("err_sat");

        // Reset arrives mid-frame, then a fresh ECR decodes normally.
        push_idle(5); syms.push_back(2'b11); syms.push_back(2'b00);
        run_epoch("partial");
        push_idle(3); push_frame(2'b11, 2'b11, 2'b11); push_idle(5);
        pin(6, 2, 0); pin(7, 2, 1); pin(8, 2, 0);
        run_epoch("after_rst");

        gen_random(700);
        run_epoch("random_a");
        gen_random(700);
        run_epoch("random_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
